// File: rtl/ysyx_22041207_trap_pkg.sv
// ysyx_22041207_trap_pkg: shared state, request-type and cause encodings for the trap controller
package ysyx_22041207_trap_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SAVE = 2'd1, MRET = 2'd2, REDIR = 2'd3} state_e;
  localparam logic [1:0] REQ_ECALL = 2'd0;
  localparam logic [1:0] REQ_ILLEGAL = 2'd1;
  localparam logic [1:0] REQ_MRET = 2'd2;
  localparam logic [1:0] REQ_RSVD = 2'd3;
  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_TIMER = 4'd7;
  localparam logic [3:0] CAUSE_ECALL = 4'd11;
  function automatic logic [3:0] sync_cause(input logic [1:0] t);
    return t == REQ_ECALL ? CAUSE_ECALL : CAUSE_ILLEGAL;
  endfunction
endpackage

// File: rtl/ysyx_22041207_trap_ctrl.sv
// ysyx_22041207_trap_ctrl: trap entry / mret sequencer with CSR strobes and fetch redirect
// Define YSYX_22041207_TIMER_IRQ_EN to add the machine timer interrupt input.
module ysyx_22041207_trap_ctrl
  import ysyx_22041207_trap_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [1:0]      req_type,
  input  logic [XLEN-1:0] req_pc,
  output logic            req_ready,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [XLEN-1:0] mstatus_i,
`ifdef YSYX_22041207_TIMER_IRQ_EN
  input  logic            irq_timer,
`endif
  output logic            wMepc,
  output logic [XLEN-1:0] mepc_v,
  output logic            wMcause,
  output logic [XLEN-1:0] mcause_v,
  output logic            panic,
  output logic            pc_mret,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            flush
);
  state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, rpc_q, rpc_d, trap_tgt;
  logic [3:0] cause_q, cause_d;
  logic irq_q, irq_d, take_irq, save;
  logic unused;
  assign unused = ^{mstatus_i, mtvec_i[1:0]};
`ifdef YSYX_22041207_TIMER_IRQ_EN
  assign take_irq = irq_timer & mstatus_i[3] & ~req_valid;
  assign trap_tgt = {mtvec_i[XLEN-1:2], 2'b00} + ((irq_q && mtvec_i[0]) ? XLEN'(4 * CAUSE_TIMER) : '0);
`else
  assign take_irq = 1'b0;
  assign trap_tgt = {mtvec_i[XLEN-1:2], 2'b00};
`endif
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    rpc_d = rpc_q;
    cause_d = cause_q;
    irq_d = irq_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = req_type == REQ_MRET ? MRET : SAVE;
          pc_d = req_pc;
          cause_d = sync_cause(req_type);
          irq_d = 1'b0;
        end else if (take_irq) begin
          state_d = SAVE;
          pc_d = req_pc;
          cause_d = CAUSE_TIMER;
          irq_d = 1'b1;
        end
      end
      SAVE: begin
        rpc_d = trap_tgt;
        state_d = REDIR;
      end
      MRET: begin
        rpc_d = mepc_i;
        state_d = REDIR;
      end
      REDIR: state_d = redirect_ready ? IDLE : REDIR;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= '0;
      rpc_q <= '0;
      cause_q <= '0;
      irq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      rpc_q <= rpc_d;
      cause_q <= cause_d;
      irq_q <= irq_d;
    end
  end
  assign save = state_q == SAVE;
  assign wMepc = save;
  assign wMcause = save;
  assign panic = save;
  assign pc_mret = state_q == MRET;
  // interrupts record the exact PC; synchronous traps record the aligned PC
  assign mepc_v = save ? (irq_q ? pc_q : {pc_q[XLEN-1:2], 2'b00}) : '0;
  assign mcause_v = save ? {irq_q, {(XLEN-5){1'b0}}, cause_q} : '0;
  assign redirect_valid = state_q == REDIR;
  assign redirect_pc = rpc_q;
  assign flush = state_q != IDLE;
  assign req_ready = state_q == IDLE;
endmodule
